// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - restoring unsigned divider, 2W-bit dividend by W-bit divisor, one quotient bit per cycle
// Optional macro DIV_EARLY_DONE_EN: div_zero/overflow cases skip RUN and finish one cycle after start.
module iterative_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_start_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [CW-1:0]    r_cnt;
  logic             r_div_zero;
  logic             r_overflow;
  logic             w_accept;
  logic             w_dz;
  logic             w_ov;
  logic             w_err;
  logic             w_last;
  logic             w_ge;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;

  assign w_accept = start && (r_state != S_RUN);
  assign w_dz     = (divisor == '0);
  assign w_ov     = !w_dz && (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign w_err    = r_div_zero || r_overflow;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // r_lo holds the unconsumed dividend bits; quotient bits shift in behind them
  assign w_trial    = {r_rem, r_lo[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_dvs});
  assign w_diff     = w_trial[WIDTH-1:0] - r_dvs;
  assign w_rem_next = w_ge ? w_diff : w_trial[WIDTH-1:0];

`ifdef DIV_EARLY_DONE_EN
  assign w_start_state = (w_dz || w_ov) ? S_DONE : S_RUN;
`else
  assign w_start_state = S_RUN;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_start_state;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? w_start_state : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= '0;
      r_lo        <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_rem      <= dividend[2*WIDTH-1:WIDTH];
      r_lo       <= dividend[WIDTH-1:0];
      r_dvs      <= divisor;
      r_cnt      <= '0;
      r_div_zero <= w_dz;
      r_overflow <= w_ov;
`ifdef DIV_EARLY_DONE_EN
      if (w_dz || w_ov) begin
        r_quotient  <= '1;
        r_remainder <= dividend[WIDTH-1:0];
      end
`endif
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      // Error runs freeze r_lo so it still holds dividend[W-1:0] for the forced remainder
      if (!w_err) begin
        r_rem <= w_rem_next;
        r_lo  <= {r_lo[WIDTH-2:0], w_ge};
      end
      if (w_last) begin
        r_quotient  <= w_err ? '1 : {r_lo[WIDTH-2:0], w_ge};
        r_remainder <= w_err ? r_lo : w_rem_next;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;
endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16: divisor, quotient and remainder width; dividend is 2*WIDTH (the multiplier product width).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to begin a division.
REQ-005 SHALL have port dividend, input, 2*WIDTH: unsigned dividend, sampled when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH: unsigned divisor, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1: division in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse; results valid.
REQ-009 SHALL have port quotient, output, WIDTH: unsigned quotient.
REQ-010 SHALL have port remainder, output, WIDTH: unsigned remainder.
REQ-011 SHALL have port div_zero, output, 1: divisor was zero.
REQ-012 SHALL have port overflow, output, 1: true quotient exceeds WIDTH bits (divisor nonzero and dividend[2W-1:W] >= divisor).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy = (state == RUN).
REQ-014 SHALL accept start only in IDLE or DONE; at that edge latch operands, clear the iteration counter and flags, and enter RUN.
REQ-015 SHALL ignore start while in RUN; latched operands are not disturbed.
REQ-016 SHALL perform restoring division, one quotient bit per RUN cycle, MSB first, using a WIDTH+1-bit partial remainder, so no intermediate bit is lost.
REQ-017 SHALL leave RUN after exactly WIDTH iterations; done is high for the single cycle in DONE, and the next cycle returns to IDLE unless start is accepted.
REQ-018 SHALL hold quotient, remainder, div_zero and overflow stable from the done cycle until the next accepted start.
REQ-019 SHALL, for non-error inputs, satisfy dividend == quotient*divisor + remainder with remainder < divisor.
REQ-020 SHALL detect div_zero and overflow from the latched operands at acceptance; on either, force quotient = all ones and remainder = dividend[WIDTH-1:0]; div_zero takes precedence, so overflow = 0 when divisor = 0.
REQ-021 SHALL, when start is asserted in the DONE cycle, accept it, drop done, and re-enter RUN on the next edge.
REQ-022 SHALL keep done low during RUN and IDLE; it never asserts for more than one consecutive cycle.

Reset
REQ-023 SHALL, on reset = 1 at a rising edge, enter IDLE with busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, overflow = 0.
REQ-024 SHALL abort a division in progress on reset and produce no done pulse for it.
REQ-025 SHALL give reset priority over start in the same cycle.

Configuration
REQ-026 SHALL honour macro DIV_EARLY_DONE_EN: when defined, an accepted start with div_zero or overflow skips RUN and enters DONE on the next edge (1-cycle latency).
REQ-027 SHALL, when DIV_EARLY_DONE_EN is undefined, run error cases through the full WIDTH RUN cycles, with the forced results of REQ-020 and the same latency as normal cases.

Verification (WIDTH = 16)
REQ-028 SHALL cover: dividend 1000000, divisor 1000 -> after 16 busy cycles done = 1, quotient 1000, remainder 0, flags 0.
REQ-029 SHALL cover: dividend 4294836225 (65535*65535), divisor 65535 -> quotient 65535, remainder 0, overflow 0; dividend 100000, divisor 7 -> quotient 14285, remainder 5.
REQ-030 SHALL cover: divisor 0, dividend 12345 -> div_zero 1, overflow 0, quotient 65535, remainder 12345; done after 1 cycle with DIV_EARLY_DONE_EN, else after 16.
REQ-031 SHALL cover: dividend 0x00010000, divisor 1 -> overflow 1, quotient 65535, remainder 0.
REQ-032 SHALL cover: start pulses with new operands at cycles 3 and 8 of RUN -> ignored, first result unchanged; reset at cycle 5 of RUN -> IDLE next cycle, no done, outputs 0.
REQ-033 SHALL cover: sweep of all dividends that are products of x, y in 0..65535 step 1000, each with divisor y ≠ 0 -> quotient x, remainder 0, zero mismatches counted.
